// File: rtl/jesd_snapshot_capture.sv
// -----------------------------------------------------------------------------
// jesd_snapshot_capture
//
// Snapshot buffer fed by the JESD receive output stream. When armed it stores
// a programmable number of consecutive valid words into block RAM. Storing
// starts either on the first valid word or on the next sync-flagged word.
// Software then reads the words back through a 2-cycle addressed read port.
//
// Optional feature macro: SNAP_TIMESTAMP_EN
//   defined   : a 64-bit counter of valid words runs freely, and trig_time
//               latches its value at the trigger word.
//   undefined : no counter is built, and trig_time is tied to 0.
//
// Handshake semantics:
//   Upstream din_vld is a qualifier only. There is no ready and no stall, so
//   every valid word seen in CAPTURE is written.
//   Read side: one rd_en produces exactly one single-cycle rd_vld pulse two
//   cycles later, carrying the data for that rd_addr. Reads are accepted every
//   cycle and in any state.
//
// Ports:
//   adc_clk, adc_rst        link clock, async active-high reset
//   din/din_vld/din_sync/din_overflow  upstream sample stream and flags
//   arm, trig_on_sync, capture_len     capture control (latched on arm)
//   busy, done, wr_count, overflow_seen, trig_time   capture status
//   rd_en, rd_addr, rd_data, rd_vld    readback port
//   dbg_state               current FSM state (0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE)
// -----------------------------------------------------------------------------
module jesd_snapshot_capture #(
    parameter int DATA_W = 512,
    parameter int ADDR_W = 10
) (
    input  logic              adc_clk,
    input  logic              adc_rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_vld,
    input  logic              din_sync,
    input  logic              din_overflow,
    input  logic              arm,
    input  logic              trig_on_sync,
    input  logic [ADDR_W:0]   capture_len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   wr_count,
    output logic              overflow_seen,
    output logic [63:0]       trig_time,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_vld,
    output logic [1:0]        dbg_state
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_LEN = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [ADDR_W:0] len_q, len_d;
    logic            trig_sync_q, trig_sync_d;
    logic [ADDR_W:0] wr_count_q, wr_count_d;
    logic            ovf_q, ovf_d;

    logic [ADDR_W:0] eff_len;
    logic [ADDR_W:0] cnt_inc;
    logic            trig_word;
    logic            wr_last;
    logic            wr_en;

    // A length of 0, or any length with the top bit set (>= DEPTH), means a
    // full buffer.
    assign eff_len   = ((capture_len == '0) || capture_len[ADDR_W]) ? FULL_LEN : capture_len;
    assign trig_word = din_vld && (din_sync || !trig_sync_q);
    assign cnt_inc   = wr_count_q + {{ADDR_W{1'b0}}, 1'b1};
    // Compare the post-write count against the length, so that DONE is
    // entered on the same edge as the final write.
    assign wr_last   = (cnt_inc == len_q);

    always_ff @(posedge adc_clk or posedge adc_rst) begin
        if (adc_rst) begin
            state_q     <= S_IDLE;
            len_q       <= FULL_LEN;
            trig_sync_q <= 1'b0;
            wr_count_q  <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            trig_sync_q <= trig_sync_d;
            wr_count_q  <= wr_count_d;
            ovf_q       <= ovf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        trig_sync_d = trig_sync_q;
        wr_count_d  = wr_count_q;
        ovf_d       = ovf_q;
        wr_en       = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                // A word arriving with arm is deliberately not captured.
                if (arm) begin
                    state_d     = S_ARMED;
                    len_d       = eff_len;
                    trig_sync_d = trig_on_sync;
                    wr_count_d  = '0;
                    ovf_d       = 1'b0;
                end
            end
            S_ARMED: begin
                if (trig_word) begin
                    wr_en      = 1'b1;
                    wr_count_d = cnt_inc;
                    state_d    = wr_last ? S_DONE : S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (din_overflow) begin
                    ovf_d = 1'b1;
                end
                if (din_vld) begin
                    wr_en      = 1'b1;
                    wr_count_d = cnt_inc;
                    if (wr_last) begin
                        state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy          = (state_q == S_ARMED) || (state_q == S_CAPTURE);
    assign done          = (state_q == S_DONE);
    assign wr_count      = wr_count_q;
    assign overflow_seen = ovf_q;
    assign dbg_state     = state_q;

`ifdef SNAP_TIMESTAMP_EN
    logic [63:0] ts_q;
    logic [63:0] trig_time_q;
    logic        trig_latch;

    assign trig_latch = (state_q == S_ARMED) && trig_word;

    // The counter holds the number of valid words seen before the current
    // one, so the trigger word latches its own zero-based index.
    always_ff @(posedge adc_clk or posedge adc_rst) begin
        if (adc_rst) begin
            ts_q        <= '0;
            trig_time_q <= '0;
        end else begin
            if (din_vld) begin
                ts_q <= ts_q + 64'd1;
            end
            if (trig_latch) begin
                trig_time_q <= ts_q;
            end
        end
    end

    assign trig_time = trig_time_q;
`else
    assign trig_time = '0;
`endif

    // Simple dual-port buffer. It has no reset so that it maps onto block RAM.
    // Only wr_count bits below the top bit are ever needed as an address,
    // because writes stop once the count reaches the length.
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] ram_rd_q;

    always_ff @(posedge adc_clk) begin
        if (wr_en) begin
            mem[wr_count_q[ADDR_W-1:0]] <= din;
        end
    end

    always_ff @(posedge adc_clk) begin
        if (rd_en) begin
            ram_rd_q <= mem[rd_addr];
        end
    end

    logic              rd_pipe_q;
    logic              rd_vld_q;
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge adc_clk or posedge adc_rst) begin
        if (adc_rst) begin
            rd_pipe_q <= 1'b0;
            rd_vld_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            rd_pipe_q <= rd_en;
            rd_vld_q  <= rd_pipe_q;
            if (rd_pipe_q) begin
                rd_data_q <= ram_rd_q;
            end
        end
    end

    assign rd_vld  = rd_vld_q;
    assign rd_data = rd_data_q;

endmodule

// File: tb/tb_jesd_snapshot_capture.sv
module tb_jesd_snapshot_capture;

    localparam int DATA_W = 512;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    // ---------------- clock / reset ----------------
    logic              adc_clk = 1'b0;
    logic              adc_rst = 1'b1;
    logic [DATA_W-1:0] din = '0;
    logic              din_vld = 1'b0;
    logic              din_sync = 1'b0;
    logic              din_overflow = 1'b0;
    logic              arm = 1'b0;
    logic              trig_on_sync = 1'b0;
    logic [ADDR_W:0]   capture_len = '0;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   wr_count;
    logic              overflow_seen;
    logic [63:0]       trig_time;
    logic              rd_en = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [DATA_W-1:0] rd_data;
    logic              rd_vld;
    logic [1:0]        dbg_state;

    always #5 adc_clk = ~adc_clk;

    longint cyc = 0;
    always @(posedge adc_clk) cyc <= cyc + 1;

    jesd_snapshot_capture #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .adc_clk(adc_clk), .adc_rst(adc_rst),
        .din(din), .din_vld(din_vld), .din_sync(din_sync), .din_overflow(din_overflow),
        .arm(arm), .trig_on_sync(trig_on_sync), .capture_len(capture_len),
        .busy(busy), .done(done), .wr_count(wr_count), .overflow_seen(overflow_seen),
        .trig_time(trig_time),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_vld(rd_vld),
        .dbg_state(dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    logic [DATA_W-1:0] exp_q[$];
    longint            exp_cyc_q[$];

    // Reference model: number of valid words since reset (timestamp source)
    // and the words a capture is expected to have stored, in order.
    longint unsigned   vld_total = 0;
    logic [DATA_W-1:0] cap_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_word();
        logic [DATA_W-1:0] w;
        w = '0;
        for (int i = 0; i < DATA_W / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    function automatic logic [63:0] exp_trig(input longint unsigned ts);
`ifdef SNAP_TIMESTAMP_EN
        return ts;
`else
        return (ts == 0) ? 64'd0 : 64'd0;
`endif
    endfunction

    // ---------------- monitor ----------------
    always @(negedge adc_clk) begin
        if (rd_vld) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rd_unexpected: got rd_vld=1 expected rd_vld=0");
            end else begin
                logic [DATA_W-1:0] e;
                longint ec;
                e  = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                if (rd_data !== e || cyc != ec) begin
                    bad++;
                    $display("FAIL rd_data: got %0h at cycle %0d expected %0h at cycle %0d", rd_data, cyc, e, ec);
                end
            end
        end else if (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
            total++;
            bad++;
            $display("FAIL rd_missing: got rd_vld=0 at cycle %0d expected rd_vld=1 at cycle %0d", cyc, exp_cyc_q[0]);
            void'(exp_q.pop_front());
            void'(exp_cyc_q.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue_read(input int addr, input logic [DATA_W-1:0] e);
        rd_en   = 1'b1;
        rd_addr = addr[ADDR_W-1:0];
        exp_q.push_back(e);
        exp_cyc_q.push_back(cyc + 2);
    endtask

    task automatic drain_reads();
        rd_en = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge adc_clk);
        @(negedge adc_clk);
        check("read_queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    // vmode: 0 continuous valid, 1 alternating valid, 2 random ~70% valid.
    // noise: stray arm and overflow pulses during capture and extra overflow
    // outside of CAPTURE, plus read gaps.
    task automatic run_capture(input bit tos, input int len_in, input int vmode,
                               input int sync_at, input bit noise);
        int  L;
        int  stored;
        int  vidx;
        bit  triggered;
        bit  exp_ovf;
        longint unsigned exp_ts;
        int  c;
        L = (len_in == 0 || len_in > DEPTH) ? DEPTH : len_in;
        cap_q.delete();
        stored = 0; vidx = 0; triggered = 0; exp_ovf = 0; exp_ts = 0;

        // Arm cycle with a valid sync word that must not be captured.
        @(posedge adc_clk); #1;
        arm          = 1'b1;
        trig_on_sync = tos;
        capture_len  = len_in[ADDR_W:0];
        din_vld      = 1'b1;
        din_sync     = 1'b1;
        din          = rand_word();
        din_overflow = noise;
        vld_total++;
        @(negedge adc_clk);

        c = 0;
        while (c < 6000 && stored < L) begin
            @(posedge adc_clk); #1;
            arm          = noise && ($urandom_range(0, 9) == 0);
            trig_on_sync = 1'($urandom);
            capture_len  = (ADDR_W+1)'($urandom);
            case (vmode)
                0:       din_vld = 1'b1;
                1:       din_vld = (c % 2 == 0);
                default: din_vld = ($urandom_range(0, 99) < 70);
            endcase
            din          = rand_word();
            din_sync     = tos ? (din_vld ? (vidx == sync_at) : 1'($urandom)) : 1'($urandom);
            din_overflow = noise && ($urandom_range(0, 7) == 0);
            if (!triggered) begin
                if (din_vld && (din_sync || !tos)) begin
                    triggered = 1;
                    exp_ts    = vld_total;
                    cap_q.push_back(din);
                    stored = 1;
                end
            end else begin
                if (din_overflow) exp_ovf = 1;
                if (din_vld) begin
                    cap_q.push_back(din);
                    stored++;
                end
            end
            if (din_vld) begin
                vld_total++;
                vidx++;
            end
            @(negedge adc_clk);
            if (c == 0) begin
                check("armed_busy", 64'(busy), 64'd1);
                check("armed_done", 64'(done), 64'd0);
                check("armed_wr_count", 64'(wr_count), 64'd0);
                check("armed_ovf_cleared", 64'(overflow_seen), 64'd0);
            end
            if (stored == L) check("busy_before_last", 64'(busy), 64'd1);
            c++;
        end
        if (stored < L) begin
            total++;
            bad++;
            $display("FAIL capture_timeout: got %0d words expected %0d", stored, L);
        end

        // Cycle after the last write: DONE. Overflow here must be ignored.
        @(posedge adc_clk); #1;
        arm = 1'b0; din_vld = 1'b0; din_sync = 1'b0; din_overflow = noise;
        @(negedge adc_clk);
        check("done", 64'(done), 64'd1);
        check("done_busy", 64'(busy), 64'd0);
        check("done_state", 64'(dbg_state), 64'd3);
        check("wr_count", 64'(wr_count), 64'(L));
        check("overflow_seen", 64'(overflow_seen), 64'(exp_ovf));
        check("trig_time", trig_time, exp_trig(exp_ts));

        // Readback of every stored word; DONE ignores further valid words.
        for (int i = 0; i < L; i++) begin
            @(posedge adc_clk); #1;
            din_overflow = 1'b0;
            din_vld = 1'($urandom);
            din     = rand_word();
            if (din_vld) vld_total++;
            if (noise && $urandom_range(0, 3) == 0) begin
                rd_en = 1'b0;
                @(posedge adc_clk); #1;
            end
            issue_read(i, cap_q[i]);
        end
        @(posedge adc_clk); #1;
        din_vld = 1'b0;
        drain_reads();
        check("ovf_after_done", 64'(overflow_seen), 64'(exp_ovf));
        check("wr_count_after_done", 64'(wr_count), 64'(L));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_wr_count"}, 64'(wr_count), 64'd0);
        check({tag, "_ovf"}, 64'(overflow_seen), 64'd0);
        check({tag, "_trig_time"}, trig_time, 64'd0);
        check({tag, "_rd_vld"}, 64'(rd_vld), 64'd0);
        check({tag, "_rd_data"}, rd_data[63:0], 64'd0);
        check({tag, "_rd_data_or"}, 64'(|rd_data), 64'd0);
        check({tag, "_state"}, 64'(dbg_state), 64'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #900000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        repeat (3) @(negedge adc_clk);
        check_reset_values("reset");
        @(posedge adc_clk); #1;
        adc_rst = 1'b0;
        vld_total = 0;
        @(negedge adc_clk);

        run_capture(1'b0, 8,    0, 0, 1'b0);  // immediate trigger
        run_capture(1'b1, 4,    0, 4, 1'b0);  // sync on the 5th valid word
        run_capture(1'b0, 3,    1, 0, 1'b0);  // gapped valid, no gaps stored
        run_capture(1'b0, 0,    2, 0, 1'b0);  // 0 means full buffer
        run_capture(1'b0, 2000, 2, 0, 1'b0);  // clamped to full buffer
        run_capture(1'b0, 20,   2, 0, 1'b1);  // overflow pulses and stray arms
        run_capture(1'b1, 6,    0, 2, 1'b0);  // arm from DONE clears overflow
        run_capture(1'b1, 1,    2, 3, 1'b1);  // length 1: ARMED straight to DONE
        for (int k = 0; k < 4; k++) begin
            run_capture(1'($urandom), $urandom_range(1, 40), 2, $urandom_range(0, 5), 1'b1);
        end

        // Reset in the middle of a capture.
        @(posedge adc_clk); #1;
        arm = 1'b1; trig_on_sync = 1'b0; capture_len = 11'd50;
        din_vld = 1'b0; din_overflow = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge adc_clk); #1;
            arm = 1'b0; din_vld = 1'b1; din = rand_word(); din_overflow = (i == 3);
        end
        @(negedge adc_clk);
        check("midcap_busy", 64'(busy), 64'd1);
        @(posedge adc_clk); #1;
        adc_rst = 1'b1;
        din_vld = 1'b0; din_overflow = 1'b0;
        vld_total = 0;
        @(negedge adc_clk);
        check_reset_values("midcap_reset");
        @(posedge adc_clk); #1;
        adc_rst = 1'b0;
        @(negedge adc_clk);
        check("post_reset_state", 64'(dbg_state), 64'd0);
        run_capture(1'b1, 5, 2, 1, 1'b0);      // recovery, timestamp restarted

        repeat (4) @(negedge adc_clk);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
